// File: rtl/axi_read_protocol.sv
// AXI read path (AR + R) as registered WAIT/COMMIT/ASSERT handshake FSMs; one burst outstanding.
// Request-to-handshake latency is 1 cycle when idle; a request arriving mid-burst is held in ASSERT until the burst ends.
module axi_read_protocol #(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic          axi_aclk,
    input  logic          rst,
    input  logic [AW-1:0] araddr_in,
    input  logic [7:0]    arlen_in,
    input  logic [2:0]    arsize_in,
    input  logic [1:0]    arburst_in,
    input  logic          arvalid_in,
    input  logic [DW-1:0] rdata_in,
    input  logic [1:0]    rresp_in,
    input  logic          rvalid_in,
    input  logic          rready_in,
    output logic [AW-1:0] axi_araddr,
    output logic [7:0]    axi_arlen,
    output logic [2:0]    axi_arsize,
    output logic [1:0]    axi_arburst,
    output logic          axi_arvalid,
    output logic          axi_arready,
    output logic [DW-1:0] axi_rdata,
    output logic [1:0]    axi_rresp,
    output logic          axi_rlast,
    output logic          axi_rvalid,
    output logic          axi_rready,
    output logic          r_busy,
    output logic          rd_err
);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'b00,
        ST_COMMIT = 2'b01,
        ST_ASSERT = 2'b10
    } hs_state_e;

    hs_state_e     ar_state_q, ar_state_d, r_state_q, r_state_d;
    logic [AW-1:0] araddr_q, araddr_d;
    logic [7:0]    arlen_q, arlen_d;
    logic [2:0]    arsize_q, arsize_d;
    logic [1:0]    arburst_q, arburst_d;
    logic          arvalid_q, arvalid_d, arready_q, arready_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;
    logic          rlast_q, rlast_d, rvalid_q, rvalid_d, rready_q, rready_d;
    logic          r_busy_q, r_busy_d, rd_err_q, rd_err_d;
    logic [7:0]    beats_left_q, beats_left_d;
    logic [7:0]    beats_dec, r_beats;
    logic          r_eval_wait;

    always_comb begin
        ar_state_d   = ar_state_q;
        r_state_d    = r_state_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arsize_d     = arsize_q;
        arburst_d    = arburst_q;
        arvalid_d    = arvalid_q;
        arready_d    = arready_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        rlast_d      = rlast_q;
        rvalid_d     = rvalid_q;
        rready_d     = rready_q;
        r_busy_d     = r_busy_q;
        rd_err_d     = rd_err_q;
        beats_left_d = beats_left_q;
        beats_dec    = (beats_left_q != 8'd0) ? beats_left_q - 8'd1 : 8'd0;
        r_beats      = beats_left_q;
        r_eval_wait  = 1'b0;

        case (ar_state_q)
            ST_WAIT: begin
                if (arvalid_in) begin
                    araddr_d  = araddr_in;
                    arlen_d   = arlen_in;
                    arsize_d  = arsize_in;
                    arburst_d = arburst_in;
                    arvalid_d = 1'b1;
                    arready_d = ~r_busy_q;
                    ar_state_d = r_busy_q ? ST_ASSERT : ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                r_busy_d     = 1'b1;
                beats_left_d = arlen_q;
                rd_err_d     = 1'b0;
                arready_d    = 1'b0;
                // A request already waiting behind this one must wait for the new burst to drain.
                if (arvalid_in) begin
                    araddr_d   = araddr_in;
                    arlen_d    = arlen_in;
                    arsize_d   = arsize_in;
                    arburst_d  = arburst_in;
                    arvalid_d  = 1'b1;
                    ar_state_d = ST_ASSERT;
                end else begin
                    arvalid_d  = 1'b0;
                    ar_state_d = ST_WAIT;
                end
            end
            ST_ASSERT: begin
                if (!r_busy_q) begin
                    arready_d  = 1'b1;
                    ar_state_d = ST_COMMIT;
                end
            end
            default: ar_state_d = ST_WAIT;
        endcase

        case (r_state_q)
            ST_WAIT: r_eval_wait = 1'b1;
            ST_COMMIT: begin
                beats_left_d = beats_dec;
                if (rresp_q[1]) rd_err_d = 1'b1;
                if (rlast_q) begin
                    r_busy_d  = 1'b0;
                    rvalid_d  = 1'b0;
                    rready_d  = 1'b0;
                    rlast_d   = 1'b0;
                    r_state_d = ST_WAIT;
                end else begin
                    // Back-to-back beats: the next beat sees the already-decremented count.
                    r_eval_wait = 1'b1;
                    r_beats     = beats_dec;
                end
            end
            ST_ASSERT: begin
                if (rready_in) begin
                    rready_d  = 1'b1;
                    r_state_d = ST_COMMIT;
                end
            end
            default: r_state_d = ST_WAIT;
        endcase

        if (r_eval_wait) begin
            rready_d = rready_in;
            if (r_busy_q && rvalid_in) begin
                rdata_d   = rdata_in;
                rresp_d   = rresp_in;
                rvalid_d  = 1'b1;
                rlast_d   = (r_beats == 8'd0);
                r_state_d = rready_in ? ST_COMMIT : ST_ASSERT;
            end else begin
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
                r_state_d = ST_WAIT;
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            ar_state_q   <= ST_WAIT;
            r_state_q    <= ST_WAIT;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arsize_q     <= '0;
            arburst_q    <= '0;
            arvalid_q    <= 1'b0;
            arready_q    <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= '0;
            rlast_q      <= 1'b0;
            rvalid_q     <= 1'b0;
            rready_q     <= 1'b0;
            r_busy_q     <= 1'b0;
            rd_err_q     <= 1'b0;
            beats_left_q <= '0;
        end else begin
            ar_state_q   <= ar_state_d;
            r_state_q    <= r_state_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arsize_q     <= arsize_d;
            arburst_q    <= arburst_d;
            arvalid_q    <= arvalid_d;
            arready_q    <= arready_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            rlast_q      <= rlast_d;
            rvalid_q     <= rvalid_d;
            rready_q     <= rready_d;
            r_busy_q     <= r_busy_d;
            rd_err_q     <= rd_err_d;
            beats_left_q <= beats_left_d;
        end
    end

    assign axi_araddr  = araddr_q;
    assign axi_arlen   = arlen_q;
    assign axi_arsize  = arsize_q;
    assign axi_arburst = arburst_q;
    assign axi_arvalid = arvalid_q;
    assign axi_arready = arready_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;
    assign axi_rlast   = rlast_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rready  = rready_q;
    assign r_busy      = r_busy_q;
    assign rd_err      = rd_err_q;

endmodule

// File: tb/tb_axi_read_protocol.sv
// Bench for axi_read_protocol: directed vector table, hand-written burst/reset sequences,
// then random master/slave traffic checked against a transaction-level scoreboard.
module tb_axi_read_protocol;

    logic        axi_aclk = 1'b0;
    logic        rst;
    logic [31:0] araddr_in;
    logic [7:0]  arlen_in;
    logic [2:0]  arsize_in;
    logic [1:0]  arburst_in;
    logic        arvalid_in;
    logic [63:0] rdata_in;
    logic [1:0]  rresp_in;
    logic        rvalid_in;
    logic        rready_in;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_arvalid, axi_arready;
    logic [63:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast, axi_rvalid, axi_rready;
    logic        r_busy, rd_err;

    always #5 axi_aclk = ~axi_aclk;

    axi_read_protocol #(.AW(32), .DW(64)) dut (
        .axi_aclk(axi_aclk), .rst(rst),
        .araddr_in(araddr_in), .arlen_in(arlen_in), .arsize_in(arsize_in),
        .arburst_in(arburst_in), .arvalid_in(arvalid_in),
        .rdata_in(rdata_in), .rresp_in(rresp_in), .rvalid_in(rvalid_in), .rready_in(rready_in),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .r_busy(r_busy), .rd_err(rd_err)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic drv(input logic arv, input logic [31:0] a, input logic [7:0] l,
                       input logic rv, input logic rr, input logic [63:0] d, input logic [1:0] rs);
        arvalid_in = arv; araddr_in = a; arlen_in = l; arsize_in = 3'd3; arburst_in = 2'd1;
        rvalid_in = rv; rready_in = rr; rdata_in = d; rresp_in = rs;
    endtask

    typedef struct {
        logic rst; logic arv; logic [31:0] addr; logic [7:0] len;
        logic rv; logic rr; logic [63:0] rd; logic [1:0] rs;
        logic e_arv; logic e_arr; logic [31:0] e_addr;
        logic e_rv; logic e_rr; logic e_last; logic [63:0] e_rdata;
        logic e_busy; logic e_err;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic arv, input logic [31:0] a, input logic [7:0] l,
                                input logic rv, input logic rr, input logic [63:0] d, input logic [1:0] rs,
                                input logic earv, input logic earr, input logic [31:0] ea,
                                input logic erv, input logic err_, input logic el, input logic [63:0] ed,
                                input logic eb, input logic ee);
        vec_t v;
        v.rst = r; v.arv = arv; v.addr = a; v.len = l; v.rv = rv; v.rr = rr; v.rd = d; v.rs = rs;
        v.e_arv = earv; v.e_arr = earr; v.e_addr = ea; v.e_rv = erv; v.e_rr = err_;
        v.e_last = el; v.e_rdata = ed; v.e_busy = eb; v.e_err = ee;
        return v;
    endfunction

    typedef struct {
        logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
    } req_t;

    vec_t tbl[17];
    req_t reqq[$];
    int   bq[$];
    int   ncomm, nlast;

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0);

        //              rst arv addr    len rv rr data     rs | arv arr addr    rv rr last rdata    busy err
        tbl[0]  = mk(1, 0, 0,       0, 0, 0, 0,       0,   0, 0, 0,       0, 0, 0, 0,       0, 0);
        tbl[1]  = mk(0, 0, 0,       0, 1, 1, 'h1111,  0,   0, 0, 0,       0, 1, 0, 0,       0, 0);
        tbl[2]  = mk(0, 0, 0,       0, 1, 1, 'h1111,  0,   0, 0, 0,       0, 1, 0, 0,       0, 0);
        tbl[3]  = mk(0, 1, 'h1000,  0, 0, 0, 0,       0,   1, 1, 'h1000,  0, 0, 0, 0,       0, 0);
        tbl[4]  = mk(0, 0, 0,       0, 0, 0, 0,       0,   0, 0, 'h1000,  0, 0, 0, 0,       1, 0);
        tbl[5]  = mk(0, 0, 0,       0, 1, 1, 'hA5A5,  0,   0, 0, 'h1000,  1, 1, 1, 'hA5A5,  1, 0);
        tbl[6]  = mk(0, 0, 0,       0, 0, 0, 0,       0,   0, 0, 'h1000,  0, 0, 0, 'hA5A5,  0, 0);
        tbl[7]  = mk(0, 1, 'h3000,  1, 0, 0, 0,       0,   1, 1, 'h3000,  0, 0, 0, 'hA5A5,  0, 0);
        tbl[8]  = mk(0, 0, 0,       0, 1, 1, 'hB1,    2,   0, 0, 'h3000,  0, 1, 0, 'hA5A5,  1, 0);
        tbl[9]  = mk(0, 0, 0,       0, 1, 1, 'hB1,    2,   0, 0, 'h3000,  1, 1, 0, 'hB1,    1, 0);
        tbl[10] = mk(0, 0, 0,       0, 1, 1, 'hB2,    0,   0, 0, 'h3000,  1, 1, 1, 'hB2,    1, 1);
        tbl[11] = mk(0, 0, 0,       0, 0, 0, 0,       0,   0, 0, 'h3000,  0, 0, 0, 'hB2,    0, 1);
        tbl[12] = mk(0, 0, 0,       0, 0, 0, 0,       0,   0, 0, 'h3000,  0, 0, 0, 'hB2,    0, 1);
        tbl[13] = mk(0, 1, 'h4000,  0, 0, 0, 0,       0,   1, 1, 'h4000,  0, 0, 0, 'hB2,    0, 1);
        tbl[14] = mk(0, 0, 0,       0, 0, 0, 0,       0,   0, 0, 'h4000,  0, 0, 0, 'hB2,    1, 0);
        tbl[15] = mk(0, 0, 0,       0, 1, 1, 'hC0,    0,   0, 0, 'h4000,  1, 1, 1, 'hC0,    1, 0);
        tbl[16] = mk(0, 0, 0,       0, 0, 0, 0,       0,   0, 0, 'h4000,  0, 0, 0, 'hC0,    0, 0);

        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].rst;
            drv(tbl[i].arv, tbl[i].addr, tbl[i].len, tbl[i].rv, tbl[i].rr, tbl[i].rd, tbl[i].rs);
            step();
            chk($sformatf("v%0d_arvalid", i), axi_arvalid, tbl[i].e_arv);
            chk($sformatf("v%0d_arready", i), axi_arready, tbl[i].e_arr);
            chk($sformatf("v%0d_araddr", i),  axi_araddr,  tbl[i].e_addr);
            chk($sformatf("v%0d_rvalid", i),  axi_rvalid,  tbl[i].e_rv);
            chk($sformatf("v%0d_rready", i),  axi_rready,  tbl[i].e_rr);
            chk($sformatf("v%0d_rlast", i),   axi_rlast,   tbl[i].e_last);
            chk($sformatf("v%0d_rdata", i),   axi_rdata,   tbl[i].e_rdata);
            chk($sformatf("v%0d_busy", i),    r_busy,      tbl[i].e_busy);
            chk($sformatf("v%0d_rd_err", i),  rd_err,      tbl[i].e_err);
        end

        // 4-beat burst, 2-cycle stall on beat 2, second request queued behind it
        drv(1, 'h100, 3, 0, 0, 0, 0); step();
        chk("A_ar_hs", {axi_arvalid, axi_arready}, 2'b11);
        chk("A_araddr", axi_araddr, 'h100);
        drv(0, 0, 0, 1, 1, 'hD1, 0); step();
        chk("A_busy", r_busy, 1);
        chk("A_rv_early", axi_rvalid, 0);
        ncomm = 0; nlast = 0;
        step(); ncomm += int'(axi_rvalid & axi_rready); nlast += int'(axi_rlast);
        chk("A_b1_data", axi_rdata, 'hD1);
        drv(1, 'h2000, 0, 1, 0, 'hD2, 0); step(); ncomm += int'(axi_rvalid & axi_rready);
        chk("A_ar_pend", {axi_arvalid, axi_arready}, 2'b10);
        chk("A_araddr2", axi_araddr, 'h2000);
        chk("A_stall1", {axi_rvalid, axi_rready}, 2'b10);
        chk("A_stall1_d", axi_rdata, 'hD2);
        drv(1, 'h2000, 0, 1, 0, 'hD3, 0); step(); ncomm += int'(axi_rvalid & axi_rready);
        chk("A_stall2", {axi_rvalid, axi_rready}, 2'b10);
        chk("A_stall2_d", axi_rdata, 'hD2);
        drv(1, 'h2000, 0, 1, 1, 'hD3, 0); step(); ncomm += int'(axi_rvalid & axi_rready); nlast += int'(axi_rlast);
        chk("A_b2_data", axi_rdata, 'hD2);
        step(); ncomm += int'(axi_rvalid & axi_rready); nlast += int'(axi_rlast);
        chk("A_b3_data", axi_rdata, 'hD3);
        chk("A_b3_last", axi_rlast, 0);
        drv(1, 'h2000, 0, 1, 1, 'hD4, 0); step(); ncomm += int'(axi_rvalid & axi_rready); nlast += int'(axi_rlast);
        chk("A_b4_data", axi_rdata, 'hD4);
        chk("A_b4_last", axi_rlast, 1);
        chk("A_commits", ncomm, 4);
        chk("A_lasts", nlast, 1);
        drv(1, 'h2000, 0, 0, 0, 0, 0); step();
        chk("A_idle_busy", r_busy, 0);
        chk("A_ar_still", {axi_arvalid, axi_arready}, 2'b10);
        step();
        chk("A_ar_go", {axi_arvalid, axi_arready}, 2'b11);
        chk("A_ar_go_addr", axi_araddr, 'h2000);
        drv(0, 0, 0, 0, 0, 0, 0); step();
        chk("A_ar_once", axi_arready, 0);
        chk("A_busy2", r_busy, 1);
        drv(0, 0, 0, 1, 1, 'hE0, 0); step();
        chk("A_e_last", {axi_rvalid, axi_rlast}, 2'b11);
        drv(0, 0, 0, 0, 0, 0, 0); step();
        chk("A_end_busy", r_busy, 0);

        // Reset during beat 2 of 4
        drv(1, 'h600, 3, 0, 0, 0, 0); step();
        drv(0, 0, 0, 1, 1, 'hF1, 2); step(); step();
        chk("B_b1", axi_rdata, 'hF1);
        drv(0, 0, 0, 1, 0, 'hF2, 0); step();
        chk("B_b2_stall", axi_rdata, 'hF2);
        rst = 1'b1; step();
        chk("B_rst_ar", {axi_arvalid, axi_arready, axi_araddr, axi_arlen}, 0);
        chk("B_rst_r", {axi_rvalid, axi_rready, axi_rlast, axi_rresp}, 0);
        chk("B_rst_data", axi_rdata, 0);
        chk("B_rst_busy", {r_busy, rd_err}, 0);
        rst = 1'b0;
        drv(1, 'h5000, 0, 0, 0, 0, 0); step();
        chk("B_ar_hs", {axi_arvalid, axi_arready}, 2'b11);
        chk("B_araddr", axi_araddr, 'h5000);
        drv(0, 0, 0, 0, 0, 0, 0); step();
        drv(0, 0, 0, 1, 1, 'h77, 0); step();
        chk("B_last", {axi_rvalid, axi_rlast, axi_rdata}, {2'b11, 64'h77});
        drv(0, 0, 0, 0, 0, 0, 0); step();
        chk("B_end_busy", r_busy, 0);

        // Random traffic against an in-order transaction scoreboard
        begin
            logic        ar_pres, r_pres, end_pend, err_acc, exp_err;
            logic [63:0] bdat;
            logic [1:0]  bresp;
            int          beat_idx, cyc;
            req_t        r;
            ar_pres = 0; r_pres = 0; end_pend = 0; err_acc = 0; exp_err = 0;
            bdat = 0; bresp = 0; beat_idx = 0; cyc = 0;
            for (int i = 0; i < 40; i++) begin
                r.addr = $urandom(); r.len = 8'($urandom_range(0, 4));
                r.size = 3'($urandom_range(0, 3)); r.burst = 2'($urandom_range(0, 2));
                reqq.push_back(r);
            end
            while ((reqq.size() > 0 || bq.size() > 0 || end_pend) && cyc < 20000) begin
                step();
                cyc++;
                if (end_pend) begin
                    chk("R_end_busy", r_busy, 0);
                    chk("R_end_err", rd_err, exp_err);
                    end_pend = 0;
                end
                if (bq.size() == 0) chk("R_rv_noaddr", axi_rvalid, 0);
                if (axi_arvalid && axi_arready) begin
                    chk("R_ar_busy", r_busy, 0);
                    if (reqq.size() > 0) begin
                        chk("R_araddr", axi_araddr, reqq[0].addr);
                        chk("R_arlen", axi_arlen, reqq[0].len);
                        chk("R_arsize", axi_arsize, reqq[0].size);
                        chk("R_arburst", axi_arburst, reqq[0].burst);
                        bq.push_back(int'(reqq[0].len));
                        void'(reqq.pop_front());
                    end else chk("R_ar_extra", reqq.size(), 1);
                    ar_pres = 0;
                end
                if (axi_rvalid && axi_rready) begin
                    chk("R_r_busy", r_busy, 1);
                    if (bq.size() > 0 && r_pres) begin
                        chk("R_rdata", axi_rdata, bdat);
                        chk("R_rresp", axi_rresp, bresp);
                        chk("R_rlast", axi_rlast, beat_idx == bq[0]);
                        err_acc = err_acc | bresp[1];
                        beat_idx++;
                        if (beat_idx > bq[0]) begin
                            void'(bq.pop_front());
                            exp_err = err_acc; err_acc = 0; beat_idx = 0; end_pend = 1;
                        end
                    end else chk("R_r_extra", bq.size(), 99);
                    r_pres = 0;
                end
                if (!ar_pres && reqq.size() > 0 && $urandom_range(0, 2) != 0) ar_pres = 1;
                if (!r_pres && $urandom_range(0, 3) != 0) begin
                    bdat  = {$urandom(), $urandom()};
                    bresp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
                    r_pres = 1;
                end
                arvalid_in = ar_pres;
                if (reqq.size() > 0) begin
                    araddr_in = reqq[0].addr; arlen_in = reqq[0].len;
                    arsize_in = reqq[0].size; arburst_in = reqq[0].burst;
                end
                rvalid_in = r_pres; rdata_in = bdat; rresp_in = bresp;
                rready_in = ($urandom_range(0, 3) != 0);
            end
            chk("R_drain", reqq.size() + bq.size(), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_read_protocol.md
Name: axi_read_protocol

Overview:
- Cycle-level FSM model of the AXI read path: AR (read address) and R (read data) channels.
- Pairs with the existing write-path FSM (AW/W/B) and drives the read-side signal set that the write path leaves unimplemented.
- Registers master requests and slave beats through WAIT/COMMIT/ASSERT handshake states.
- Tracks burst length and generates axi_rlast; one outstanding read burst at a time.

Parameters:
AW, 32, address width
DW, 64, read data width

Ports:
axi_aclk  in  1  clock
rst  in  1  reset, synchronous, active-high
araddr_in  in  AW  requested read address
arlen_in  in  8  requested burst length minus one
arsize_in  in  3  requested beat size
arburst_in  in  2  requested burst type
arvalid_in  in  1  master request valid
rdata_in  in  DW  slave beat data
rresp_in  in  2  slave beat response
rvalid_in  in  1  slave beat valid
rready_in  in  1  master ready for beat
axi_araddr  out  AW  registered read address
axi_arlen  out  8  registered burst length
axi_arsize  out  3  registered burst size
axi_arburst  out  2  registered burst type
axi_arvalid  out  1  read address valid
axi_arready  out  1  read address ready
axi_rdata  out  DW  registered beat data
axi_rresp  out  2  registered beat response
axi_rlast  out  1  last beat of burst
axi_rvalid  out  1  beat valid
axi_rready  out  1  beat ready
r_busy  out  1  burst in progress (internal r_active)
rd_err  out  1  sticky: any beat of current burst had rresp[1]=1

Behaviour:
- Clock axi_aclk; reset rst synchronous, active-high.
- Reset: every output 0; ar_state = r_state = WAIT; beats_left = 0.
  - Reset mid-burst drops the burst; the next arvalid_in is accepted normally.
- State encoding: WAIT = 2'b00, COMMIT = 2'b01 (valid & ready), ASSERT = 2'b10 (valid, not ready).

AR FSM:
- WAIT:
  - arvalid_in and ~r_busy: capture ar*_in, arvalid = 1, arready = 1, go to COMMIT.
  - arvalid_in and r_busy: capture ar*_in, arvalid = 1, arready = 0, go to ASSERT.
  - Otherwise: hold.
- COMMIT (exactly 1 cycle):
  - Set r_busy = 1, beats_left = axi_arlen, rd_err = 0, arready = 0.
  - If arvalid_in: capture the new request, keep arvalid = 1, go to ASSERT.
  - Else: arvalid = 0, go to WAIT.
- ASSERT:
  - Hold address fields stable.
  - When ~r_busy: arready = 1, go to COMMIT.
- Latency: request to handshake visible is 1 cycle when idle.

R FSM:
- WAIT:
  - rvalid_in is ignored while ~r_busy (no data before address).
  - r_busy and rvalid_in and rready_in: capture rdata/rresp, rvalid = 1, rready = 1, rlast = (beats_left == 0), go to COMMIT.
  - r_busy and rvalid_in only: capture, rvalid = 1, rready = 0, rlast as above, go to ASSERT.
  - Otherwise: axi_rready follows rready_in.
- COMMIT (beat transferred):
  - beats_left decrements (8-bit, no wrap: never decremented below 0).
  - If rresp[1] = 1, set rd_err.
  - If axi_rlast: r_busy = 0, rvalid = 0, rready = 0, rlast = 0, go to WAIT.
  - Else: evaluate next beat with the WAIT rules in the same cycle (back-to-back beats allowed).
- ASSERT:
  - Data, resp and rlast held stable.
  - When rready_in: rready = 1, go to COMMIT.
- Burst of arlen+1 beats (1..256); axi_rlast is asserted only on beat arlen+1.
- Simultaneous events:
  - AR COMMIT and R COMMIT never overlap.
  - When the last R COMMIT clears r_busy, a pending AR ASSERT moves to COMMIT on the following cycle.
- rd_err holds its value after the burst until the next AR COMMIT.

Test Plan:
- Idle, arvalid_in = 1, araddr_in = 0x1000, arlen_in = 0 -> next cycle axi_arvalid = 1, axi_arready = 1, axi_araddr = 0x1000. Then rvalid_in = rready_in = 1, rdata_in = 0xA5A5 -> axi_rvalid = 1, axi_rready = 1, axi_rlast = 1, axi_rdata = 0xA5A5. r_busy = 0 one cycle later.
- arlen_in = 3; rready_in low for 2 cycles on beat 2 -> R ASSERT with axi_rdata stable for 2 cycles. Exactly 4 COMMITs; axi_rlast = 1 only on the 4th.
- Second arvalid_in (araddr_in = 0x2000) during an active 4-beat burst -> axi_arvalid = 1, axi_arready = 0 until the cycle after the last beat. Then axi_arready = 1 for exactly 1 cycle with axi_araddr = 0x2000.
- rvalid_in = 1 with no accepted address -> axi_rvalid stays 0, r_state stays WAIT.
- arlen_in = 1, beat 1 rresp_in = 2'b10, beat 2 rresp_in = 2'b00 -> rd_err = 1 after beat 1 and held after the burst. Cleared on the next AR COMMIT.
- rst asserted during beat 2 of 4 -> all outputs 0 next cycle, r_busy = 0. Next arvalid_in is accepted in 1 cycle.
